i2c_slave: RTL and testbench
============================

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 The block SHALL have parameter ADDR, default 7'h21, the 7-bit target address it answers to.
REQ-002 The block SHALL have port clk, input, 1, the system clock, at least 16x the SCL rate.
REQ-003 The block SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-004 The block SHALL have port scl, input, 1, the raw I2C clock line.
REQ-005 The block SHALL have port sda_in, input, 1, the raw I2C data line.
REQ-006 The block SHALL have port sda_oe, output, 1; 1 means pull SDA low (open-drain); 0 means release SDA.
REQ-007 The block SHALL have port rx_data, output, 8, the last byte written by the master.
REQ-008 The block SHALL have port rx_valid, output, 1, a one-clk strobe when rx_data updates.
REQ-009 The block SHALL have port tx_data, input, 8, the byte to return on a master read.
REQ-010 The block SHALL have port tx_req, output, 1, a one-clk strobe when tx_data is latched.
REQ-011 The block SHALL have port busy, output, 1, high from an addressed START until the next STOP or START.

Function
REQ-012 The block SHALL pass scl and sda_in through 2-flop synchronisers, then a 1-flop edge detector; all decisions SHALL use the synchronised signals.
REQ-013 The block SHALL detect START as synced SDA falling while synced SCL is high, and STOP as synced SDA rising while synced SCL is high.
REQ-014 START or repeated START SHALL force state ADDR and clear the bit counter from any state; STOP SHALL force state IDLE from any state. Both SHALL release sda_oe.
REQ-015 The states SHALL be IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK and IGNORE.
REQ-016 Data SHALL be sampled on the synced SCL rising edge, MSB first. A 3-bit counter SHALL mark bit 7 down to 0.
REQ-017 sda_oe SHALL change only on a synced SCL falling edge, except on the release cases in REQ-014.
REQ-018 ADDR: after 8 bits, if bits[7:1]==ADDR the block SHALL go to ADDR_ACK and assert sda_oe on that falling edge. Otherwise it SHALL go to IGNORE with sda_oe held 0.
REQ-019 ADDR_ACK: on the ninth falling edge, with R/W=0 the block SHALL release sda_oe and enter WRITE.
REQ-020 ADDR_ACK with R/W=1: the block SHALL latch tx_data, pulse tx_req, drive sda_oe = ~tx_data[7] and enter READ.
REQ-021 WRITE: after 8 bits the block SHALL update rx_data, pulse rx_valid on the same clk as the eighth rising-edge sample, and enter WRITE_ACK.
REQ-022 WRITE_ACK: the block SHALL assert sda_oe on the eighth falling edge, release it on the ninth falling edge, and return to WRITE.
REQ-023 READ: the block SHALL drive sda_oe = ~bit for each bit, shifting on falling edges, and release SDA after bit 0 for the master ACK.
REQ-024 READ_ACK: the block SHALL sample the master ACK on the rising edge. ACK (SDA low) SHALL reload tx_data, pulse tx_req and continue in READ. NACK SHALL enter IGNORE.
REQ-025 IGNORE SHALL hold sda_oe=0 until START or STOP.
REQ-026 If START and STOP are seen in the same clk, STOP SHALL win.
REQ-027 rx_valid and tx_req SHALL never be high for more than one clk per byte.

Reset
REQ-028 Reset SHALL immediately force: state IDLE, sda_oe 0, rx_data 8'h00, rx_valid 0, tx_req 0, busy 0, bit counter 0, and synchroniser flops 1 (bus idle).
REQ-029 Reset asserted mid-transfer SHALL release SDA within the same cycle, asynchronously.
REQ-030 After reset deasserts, the block SHALL ignore traffic until the next START.

Structure
REQ-031 The state encoding localparams SHALL live in a shared package, i2c_pkg, with the ADDR default.
REQ-032 The synchroniser and edge detector SHALL be one sub-module, i2c_sync, instantiated once for each line.
REQ-033 The block SHALL be synthesisable, with a single clock domain and no latches.

Verification
REQ-034 Write: START, 0x42 (0x21 write), 0xA5, STOP -> ACK on both ninth clocks, rx_data=0xA5 with one rx_valid pulse, busy falling after STOP.
REQ-035 Wrong address: START, 0x44, 0x11 -> sda_oe 0 throughout, no rx_valid, state IGNORE until STOP.
REQ-036 Read: tx_data=0x3C, START, 0x43, master ACK, then NACK -> SDA bits 00111100 twice, two tx_req pulses, released after NACK.
REQ-037 Repeated START: START, 0x42, 0x01, START, 0x43 -> rx_data=0x01, then READ entered with no STOP between.
REQ-038 Reset mid-byte: reset during bit 4 of WRITE -> sda_oe 0 in the same cycle, rx_valid never pulses, bytes ignored until a new START.
REQ-039 SDA glitch while SCL high mid-byte (STOP then START) -> IDLE, then ADDR, with the counter cleared.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: state encoding and default address.
package i2c_pkg;

  localparam logic [6:0] I2C_ADDR_DEFAULT = 7'h21;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WRITE     = 3'd3,
    ST_WRITE_ACK = 3'd4,
    ST_READ      = 3'd5,
    ST_READ_ACK  = 3'd6,
    ST_IGNORE    = 3'd7
  } i2c_state_t;

endpackage

// File: rtl/i2c_sync.sv
// Two-flop synchroniser plus one-flop edge detector for one raw I2C line.
// Flops reset to 1 so a freshly reset block sees an idle bus.
module i2c_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  // Synchronise the raw line and keep one cycle of history for edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign dout = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: answers to ADDR, receives write bytes, returns tx_data on reads.
// Strobes: rx_valid is a one-clk pulse whenever rx_data takes a new byte;
// tx_req is a one-clk pulse whenever tx_data is latched for transmission.
// Neither has a ready; the user must accept/provide data on the pulse.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR = I2C_ADDR_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic [2:0] state_dbg
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_sync u_sync_scl (
    .clk(clk), .reset(reset), .din(scl),
    .dout(scl_s), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_sync u_sync_sda (
    .clk(clk), .reset(reset), .din(sda_in),
    .dout(sda_s), .rise(sda_rise), .fall(sda_fall)
  );

  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;

  i2c_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;          // bits sampled in the current byte
  logic       done_q, done_d;        // byte complete / ack phase pending
  logic [7:0] shift_q, shift_d;      // receive shifter (address or data)
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       oe_q, oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       busy_q, busy_d;

  // State register and datapath flops; reset releases SDA immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      done_q     <= 1'b0;
      shift_q    <= 8'h00;
      tx_shift_q <= 8'h00;
      oe_q       <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      oe_q       <= oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic; bus conditions override everything, STOP beats START.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    oe_d       = oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;
    if (stop_det) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
      done_d  = 1'b0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = ST_ADDR;
      cnt_d   = 3'd0;
      done_d  = 1'b0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) done_d = 1'b1;
          end else if (scl_fall && done_q) begin
            done_d = 1'b0;
            if (shift_q[7:1] == ADDR) begin
              state_d = ST_ADDR_ACK;
              oe_d    = 1'b1;
              busy_d  = 1'b1;
            end else begin
              state_d = ST_IGNORE;
              oe_d    = 1'b0;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d  = 3'd0;
            done_d = 1'b0;
            if (shift_q[0]) begin
              tx_shift_d = tx_data;
              tx_req_d   = 1'b1;
              oe_d       = ~tx_data[7];
              state_d    = ST_READ;
            end else begin
              oe_d    = 1'b0;
              state_d = ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_d  = {shift_q[6:0], sda_s};
              rx_valid_d = 1'b1;
              done_d     = 1'b0;
              state_d    = ST_WRITE_ACK;
            end
          end
        end
        ST_WRITE_ACK: begin
          // First falling edge drives the ACK, the second one ends it.
          if (scl_fall) begin
            if (!done_q) begin
              oe_d   = 1'b1;
              done_d = 1'b1;
            end else begin
              oe_d    = 1'b0;
              done_d  = 1'b0;
              cnt_d   = 3'd0;
              state_d = ST_WRITE;
            end
          end
        end
        ST_READ: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) done_d = 1'b1;
          end else if (scl_fall) begin
            if (done_q) begin
              oe_d    = 1'b0;
              done_d  = 1'b0;
              state_d = ST_READ_ACK;
            end else begin
              oe_d       = ~tx_shift_q[6];
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
          end
        end
        ST_READ_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              tx_shift_d = tx_data;
              tx_req_d   = 1'b1;
              done_d     = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end else if (scl_fall && done_q) begin
            oe_d    = ~tx_shift_q[7];
            done_d  = 1'b0;
            cnt_d   = 3'd0;
            state_d = ST_READ;
          end
        end
        default: begin
          // IDLE and IGNORE wait for a bus condition with SDA released.
        end
      endcase
    end
  end

  assign sda_oe    = oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-level I2C master tasks, write scoreboard, read checks.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int Q = 20;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       sda_m;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int rx_cnt   = 0;
  int tx_cnt   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rd_exp_q[$];

  // Open-drain wire: low if either side pulls.
  assign sda_in = sda_m & ~sda_oe;

  i2c_slave #(.ADDR(7'h21)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda_in(sda_in), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req),
    .busy(busy), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard for received bytes and strobe-width checks.
  logic rx_valid_prev = 1'b0;
  logic tx_req_prev   = 1'b0;
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rx_unexpected: got rx_data=%02h, none expected", rx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rx_data !== e) begin
          n_fail++;
          $display("FAIL rx_data: got %02h expected %02h", rx_data, e);
        end
      end
      if (rx_valid_prev === 1'b1) begin
        n_fail++;
        $display("FAIL rx_valid_width: high for 2+ clks, expected 1");
      end
    end
    if (tx_req === 1'b1) begin
      tx_cnt++;
      if (tx_req_prev === 1'b1) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_req_width: high for 2+ clks, expected 1");
      end
    end
    rx_valid_prev = rx_valid;
    tx_req_prev   = tx_req;
  end

  // Counts clocks where SDA is pulled while the watch is armed.
  logic oe_watch = 1'b0;
  int   oe_viol  = 0;
  always @(negedge clk) if (oe_watch && sda_oe === 1'b1) oe_viol++;

  // Driver tasks
  task automatic wait_q(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q(Q);
    scl   = 1'b1; wait_q(Q);
    sda_m = 1'b0; wait_q(Q);
    scl   = 1'b0; wait_q(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q(Q);
    scl   = 1'b1; wait_q(Q);
    sda_m = 1'b1; wait_q(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_q(Q);
    scl = 1'b1; wait_q(2 * Q);
    scl = 1'b0; wait_q(Q);
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    sda_m = 1'b1; wait_q(Q);
    scl = 1'b1; wait_q(Q);
    ack = ~sda_in;
    wait_q(Q);
    scl = 1'b0; wait_q(Q);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b);
    b = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wait_q(Q);
      scl = 1'b1; wait_q(Q);
      b[i] = sda_in;
      wait_q(Q);
      scl = 1'b0; wait_q(Q);
    end
    sda_m = ~ack; wait_q(Q);
    scl = 1'b1; wait_q(2 * Q);
    scl = 1'b0; wait_q(Q);
    sda_m = 1'b1;
  endtask

  // Tests
  task automatic test_reset();
    reset = 1'b1; scl = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
    wait_q(3);
    n_checks++; if (sda_oe !== 1'b0)      begin n_fail++; $display("FAIL reset_oe: got %b expected 0", sda_oe); end
    n_checks++; if (rx_data !== 8'h00)    begin n_fail++; $display("FAIL reset_rx_data: got %02h expected 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    n_checks++; if (tx_req !== 1'b0)      begin n_fail++; $display("FAIL reset_tx_req: got %b expected 0", tx_req); end
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE); end
    reset = 1'b0;
    wait_q(5);
  endtask

  task automatic test_write();
    logic ack;
    int rx0;
    rx0 = rx_cnt;
    i2c_start();
    send_byte(8'h42, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL write_addr_ack: got %b expected 1", ack); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy: got %b expected 1", busy); end
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL write_data_ack: got %b expected 1", ack); end
    i2c_stop();
    wait_q(5);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_after_stop: got %b expected 0", busy); end
    n_checks++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL write_state_after_stop: got %0d expected %0d", state_dbg, ST_IDLE); end
    n_checks++; if (rx_cnt - rx0 !== 1) begin n_fail++; $display("FAIL write_rx_pulses: got %0d expected 1", rx_cnt - rx0); end
    n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL write_rx_data_hold: got %02h expected a5", rx_data); end
  endtask

  task automatic test_wrong_addr();
    logic ack;
    int rx0;
    rx0 = rx_cnt;
    oe_viol = 0;
    oe_watch = 1'b1;
    i2c_start();
    send_byte(8'h44, ack);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_ack: got %b expected 0", ack); end
    n_checks++; if (state_dbg !== ST_IGNORE) begin n_fail++; $display("FAIL wrong_addr_state: got %0d expected %0d", state_dbg, ST_IGNORE); end
    send_byte(8'h11, ack);
    n_checks++; if (state_dbg !== ST_IGNORE) begin n_fail++; $display("FAIL wrong_addr_state2: got %0d expected %0d", state_dbg, ST_IGNORE); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_busy: got %b expected 0", busy); end
    i2c_stop();
    wait_q(5);
    oe_watch = 1'b0;
    n_checks++; if (oe_viol !== 0) begin n_fail++; $display("FAIL wrong_addr_oe: got %0d pulled clks expected 0", oe_viol); end
    n_checks++; if (rx_cnt - rx0 !== 0) begin n_fail++; $display("FAIL wrong_addr_rx: got %0d pulses expected 0", rx_cnt - rx0); end
    n_checks++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL wrong_addr_stop: got %0d expected %0d", state_dbg, ST_IDLE); end
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] b, e;
    int tx0;
    tx0 = tx_cnt;
    tx_data = 8'h3C;
    rd_exp_q.push_back(8'h3C);
    rd_exp_q.push_back(8'h3C);
    i2c_start();
    send_byte(8'h43, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL read_addr_ack: got %b expected 1", ack); end
    for (int k = 0; k < 2; k++) begin
      read_byte(k == 0, b);
      e = rd_exp_q.pop_front();
      n_checks++; if (b !== e) begin n_fail++; $display("FAIL read_byte%0d: got %02h expected %02h", k, b, e); end
    end
    wait_q(5);
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL read_release: got %b expected 0", sda_oe); end
    n_checks++; if (state_dbg !== ST_IGNORE) begin n_fail++; $display("FAIL read_nack_state: got %0d expected %0d", state_dbg, ST_IGNORE); end
    n_checks++; if (tx_cnt - tx0 !== 2) begin n_fail++; $display("FAIL read_tx_req: got %0d pulses expected 2", tx_cnt - tx0); end
    i2c_stop();
    wait_q(5);
  endtask

  task automatic test_repeated_start();
    logic ack;
    logic [7:0] b;
    i2c_start();
    send_byte(8'h42, ack);
    exp_q.push_back(8'h01);
    send_byte(8'h01, ack);
    i2c_start();
    send_byte(8'h43, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rstart_ack: got %b expected 1", ack); end
    n_checks++; if (state_dbg !== ST_READ) begin n_fail++; $display("FAIL rstart_state: got %0d expected %0d", state_dbg, ST_READ); end
    n_checks++; if (rx_data !== 8'h01) begin n_fail++; $display("FAIL rstart_rx_data: got %02h expected 01", rx_data); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstart_busy: got %b expected 1", busy); end
    read_byte(1'b0, b);
    n_checks++; if (b !== 8'h3C) begin n_fail++; $display("FAIL rstart_read: got %02h expected 3c", b); end
    i2c_stop();
    wait_q(5);
  endtask

  task automatic test_reset_mid();
    logic ack;
    int rx0;
    // Reset while the address ACK is being driven.
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(i == 6 || i == 1);
    sda_m = 1'b1; wait_q(2);
    n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rmid_ack_driven: got %b expected 1", sda_oe); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rmid_async_release: got %b expected 0", sda_oe); end
    wait_q(3);
    reset = 1'b0;
    wait_q(Q);
    i2c_stop();
    // Reset during bit 4 of a write byte.
    rx0 = rx_cnt;
    i2c_start();
    send_byte(8'h42, ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
    sda_m = 1'b1; wait_q(Q);
    scl = 1'b1; wait_q(Q);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rmid_bit4_oe: got %b expected 0", sda_oe); end
    n_checks++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL rmid_bit4_state: got %0d expected %0d", state_dbg, ST_IDLE); end
    wait_q(3);
    reset = 1'b0;
    wait_q(Q);
    scl = 1'b0; wait_q(Q);
    write_bit(1'b0); write_bit(1'b1); write_bit(1'b1); write_bit(1'b0);
    sda_m = 1'b1; wait_q(Q);
    scl = 1'b1; wait_q(Q);
    ack = ~sda_in;
    wait_q(Q);
    scl = 1'b0; wait_q(Q);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rmid_no_ack: got %b expected 0", ack); end
    send_byte(8'h42, ack);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rmid_ignored_byte: got ack %b expected 0", ack); end
    n_checks++; if (rx_cnt - rx0 !== 0) begin n_fail++; $display("FAIL rmid_rx: got %0d pulses expected 0", rx_cnt - rx0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    // A new START brings the target back.
    i2c_start();
    send_byte(8'h42, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rmid_recover_ack: got %b expected 1", ack); end
    exp_q.push_back(8'h77);
    send_byte(8'h77, ack);
    i2c_stop();
    wait_q(5);
  endtask

  task automatic test_glitch();
    logic ack;
    i2c_start();
    send_byte(8'h42, ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
    sda_m = 1'b0; wait_q(Q);
    scl = 1'b1; wait_q(Q);
    sda_m = 1'b1; wait_q(8);
    n_checks++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL glitch_stop_state: got %0d expected %0d", state_dbg, ST_IDLE); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b expected 0", busy); end
    sda_m = 1'b0; wait_q(8);
    n_checks++; if (state_dbg !== ST_ADDR) begin n_fail++; $display("FAIL glitch_start_state: got %0d expected %0d", state_dbg, ST_ADDR); end
    wait_q(Q);
    scl = 1'b0; wait_q(Q);
    send_byte(8'h42, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL glitch_addr_ack: got %b expected 1", ack); end
    exp_q.push_back(8'h3E);
    send_byte(8'h3E, ack);
    i2c_stop();
    wait_q(5);
  endtask

  task automatic test_back_to_back();
    logic ack;
    logic [7:0] v;
    int rx0;
    rx0 = rx_cnt;
    i2c_start();
    send_byte(8'h42, ack);
    for (int k = 0; k < 4; k++) begin
      v = 8'($urandom_range(0, 255));
      exp_q.push_back(v);
      send_byte(v, ack);
      n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack%0d: got %b expected 1", k, ack); end
    end
    i2c_stop();
    wait_q(5);
    n_checks++; if (rx_cnt - rx0 !== 4) begin n_fail++; $display("FAIL b2b_rx_pulses: got %0d expected 4", rx_cnt - rx0); end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_repeated_start();
    test_reset_mid();
    test_glitch();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d bytes left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
